// File: rtl/jk_pkg.sv
// Shared types and the JK next-state helper for the JK bank arbiter.
package jk_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    APPLY = 2'b01,
    ACK   = 2'b10
  } jk_state_t;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    case ({j, k})
      2'b00:   r = q;
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      2'b11:   r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after rr_ptr, wrapping.
module jk_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic [N_REQ-1:0] exclude,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

  logic [N_REQ-1:0] cand_s;
  logic [IDX_W:0]   sum_s;
  logic [IDX_W-1:0] idx_s;

  assign cand_s = req & ~exclude;

  // Walk from the farthest slot to the nearest so the candidate closest to rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum_s       = '0;
    idx_s       = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum_s       = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      idx_s       = (sum_s >= N_L) ? IDX_W'(sum_s - N_L) : sum_s[IDX_W-1:0];
      grant_valid = grant_valid | cand_s[idx_s];
      grant_idx   = cand_s[idx_s] ? idx_s : grant_idx;
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Bank of JK flip-flops updated through one shared J/K path, granted round-robin
// to N_REQ requesters; each grant takes an APPLY cycle and an ACK cycle.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int                N_REQ     = 4,
  parameter int                BANK_W    = 8,
  parameter logic [BANK_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [2*N_REQ-1:0]        op,
  input  logic [BANK_W*N_REQ-1:0]   mask,
  output logic [N_REQ-1:0]          ack,
  output logic                      busy,
  output logic [BANK_W-1:0]         q,
  output logic [BANK_W-1:0]         qn,
  output logic [CNT_W-1:0]          ops_done
);

  localparam int IDX_W = $clog2(N_REQ);

  jk_state_t         state_r, next_state_s;
  logic [IDX_W-1:0]  grant_idx_r, rr_ptr_r, arb_idx_s;
  jk_op_t            op_r;
  logic [BANK_W-1:0] mask_r, q_r, qn_r, q_next_s, sel_mask_s;
  logic [N_REQ-1:0]  ack_r, ack_next_s, excl_s, served_oh_s;
  logic              busy_r, arb_valid_s, j_s, k_s;
  logic [1:0]        sel_op_s;
  logic [CNT_W-1:0]  ops_done_r;

  assign served_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_idx_r;
  // The requester just served sits out the arbitration made during its ack cycle.
  assign excl_s      = (state_r == ACK) ? served_oh_s : '0;

  jk_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req         (req),
    .rr_ptr      (rr_ptr_r),
    .exclude     (excl_s),
    .grant_valid (arb_valid_s),
    .grant_idx   (arb_idx_s)
  );

  // Select the winning requester's op and mask from the flattened buses.
  always_comb begin
    sel_op_s   = op[1:0];
    sel_mask_s = mask[BANK_W-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      sel_op_s   = (arb_idx_s == IDX_W'(i)) ? op[2*i +: 2] : sel_op_s;
      sel_mask_s = (arb_idx_s == IDX_W'(i)) ? mask[i*BANK_W +: BANK_W] : sel_mask_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = arb_valid_s ? APPLY : IDLE;
      APPLY:   next_state_s = ACK;
      ACK:     next_state_s = arb_valid_s ? APPLY : IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output logic: J/K decode of the latched op, bank update and ack pulse.
  always_comb begin
    j_s = 1'b0;
    k_s = 1'b0;
    case (op_r)
      HOLD:    begin j_s = 1'b0; k_s = 1'b0; end
      RST:     begin j_s = 1'b0; k_s = 1'b1; end
      SET:     begin j_s = 1'b1; k_s = 1'b0; end
      TGL:     begin j_s = 1'b1; k_s = 1'b1; end
      default: begin j_s = 1'b0; k_s = 1'b0; end
    endcase
    q_next_s   = q_r;
    ack_next_s = '0;
    if (state_r == APPLY) begin
      for (int b = 0; b < BANK_W; b++) begin
        q_next_s[b] = mask_r[b] ? jk_next(q_r[b], j_s, k_s) : q_r[b];
      end
      ack_next_s = served_oh_s;
    end else begin
      q_next_s   = q_r;
      ack_next_s = '0;
    end
  end

  // State, bank, grant latch, round-robin pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      grant_idx_r <= '0;
      rr_ptr_r    <= '0;
      op_r        <= HOLD;
      mask_r      <= '0;
      q_r         <= RESET_VAL;
      qn_r        <= ~RESET_VAL;
      ack_r       <= '0;
      busy_r      <= 1'b0;
      ops_done_r  <= '0;
    end else begin
      state_r <= next_state_s;
      q_r     <= q_next_s;
      qn_r    <= ~q_next_s;
      ack_r   <= ack_next_s;
      busy_r  <= (next_state_s != IDLE);
      if (state_r == APPLY) begin
        ops_done_r <= ops_done_r + CNT_W'(1);
        rr_ptr_r   <= (grant_idx_r == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_r + IDX_W'(1);
      end
      if (next_state_s == APPLY) begin
        grant_idx_r <= arb_idx_s;
        op_r        <= jk_op_t'(sel_op_s);
        mask_r      <= sel_mask_s;
      end
    end
  end

  assign ack      = ack_r;
  assign busy     = busy_r;
  assign q        = q_r;
  assign qn       = qn_r;
  assign ops_done = ops_done_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Self-checking bench for jk_bank_arbiter: directed steps then random traffic,
// all compared against a transaction-level reference model.
module tb_jk_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] mask;
  logic [3:0]  ack;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  qn;
  logic [3:0]  ops_done;

  int tests = 0;
  int fails = 0;

  // Reference model: phase 0 idle, 1 applying, 2 acknowledging.
  logic [7:0] m_q;
  logic [1:0] m_op;
  logic [7:0] m_mask;
  logic [3:0] m_ack;
  int         m_phase, m_g, m_rr, m_cnt;

  jk_bank_arbiter #(
    .N_REQ(4), .BANK_W(8), .RESET_VAL(8'hA5), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .mask(mask),
    .ack(ack), .busy(busy), .q(q), .qn(qn), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 8'hA5; m_phase = 0; m_g = 0; m_rr = 0; m_cnt = 0; m_ack = 4'b0000;
    m_op = 2'b00; m_mask = 8'h00;
  endtask

  task automatic step();
    int excl;
    int pick;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_ack = 4'b0000;
      if (m_phase == 1) begin
        for (int b = 0; b < 8; b++) begin
          if (m_mask[b]) begin
            case (m_op)
              2'b01:   m_q[b] = 1'b0;
              2'b10:   m_q[b] = 1'b1;
              2'b11:   m_q[b] = ~m_q[b];
              default: m_q[b] = m_q[b];
            endcase
          end
        end
        m_ack[m_g] = 1'b1;
        m_cnt      = (m_cnt + 1) % 16;
        m_rr       = (m_g + 1) % 4;
        m_phase    = 2;
      end else begin
        excl = (m_phase == 2) ? m_g : -1;
        pick = -1;
        for (int i = 0; i < 4; i++) begin
          int c;
          c = (m_rr + i) % 4;
          if (pick < 0 && req[c] && c != excl) pick = c;
        end
        if (pick >= 0) begin
          m_g     = pick;
          m_op    = op[2*pick +: 2];
          m_mask  = mask[8*pick +: 8];
          m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
    end
    #1;
  endtask

  task automatic check_all();
    logic [7:0] e_qn;
    e_qn = ~m_q;
    chk("q", 32'(q), 32'(m_q));
    chk("qn", 32'(qn), 32'(e_qn));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("ops_done", 32'(ops_done), 32'(m_cnt));
  endtask

  // One full transaction from IDLE by a single requester.
  task automatic do_op(input int idx, input logic [1:0] o, input logic [7:0] mk,
                       input logic [7:0] exp_q);
    logic [3:0] e_ack;
    e_ack = 4'b0001 << idx;
    req = 4'b0000;
    req[idx] = 1'b1;
    op[2*idx +: 2] = o;
    mask[8*idx +: 8] = mk;
    step(); check_all();
    chk("op_no_ack_yet", 32'(ack), 32'h0);
    step(); check_all();
    chk("op_ack", 32'(ack), 32'(e_ack));
    chk("op_q", 32'(q), 32'(exp_q));
    req = 4'b0000;
    step(); check_all();
  endtask

  initial begin
    logic [3:0] e_ack;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1; req = 4'b0000; op = 8'h00; mask = 32'h0;
    model_reset();
    step(); step();
    check_all();
    chk("rst_q", 32'(q), 32'hA5);
    chk("rst_qn", 32'(qn), 32'h5A);
    rst = 1'b0;
    step(); check_all();

    do_op(0, 2'b10, 8'h0F, 8'hAF);
    chk("single_cnt", 32'(ops_done), 32'd1);
    do_op(2, 2'b11, 8'hFF, 8'h50);
    do_op(2, 2'b11, 8'hFF, 8'hAF);
    do_op(2, 2'b00, 8'hFF, 8'hAF);
    chk("tgl_hold_cnt", 32'(ops_done), 32'd4);
    do_op(3, 2'b10, 8'h00, 8'hAF);
    chk("zero_mask_cnt", 32'(ops_done), 32'd5);

    // Fairness: all requesters held continuously.
    req = 4'hF; op = 8'b11_10_01_11; mask = 32'h3C_81_F0_0F;
    for (int k = 0; k < 10; k++) begin
      step(); check_all();
      e_ack = (k % 2 == 1) ? (4'b0001 << order[k/2]) : 4'b0000;
      chk("fair_ack", 32'(ack), 32'(e_ack));
    end
    req = 4'b0000;
    step(); check_all();

    // Served requester excluded for the arbitration in its own ack cycle.
    req = 4'b1010;
    step(); check_all();
    step(); check_all();
    chk("excl_ack1", 32'(ack), 32'h2);
    step(); check_all();
    step(); check_all();
    chk("excl_ack3", 32'(ack), 32'h8);
    req = 4'b0010;
    step(); check_all();
    step(); check_all();
    chk("excl_ack1_again", 32'(ack), 32'h2);
    req = 4'b0000;
    step(); check_all();

    // Counter wrap at 17 completed operations with a 4-bit counter.
    while (m_cnt != 1) begin
      req = 4'b0001 << $urandom_range(3, 0);
      op = 8'($urandom); mask = $urandom;
      step(); step();
      req = 4'b0000;
      step(); check_all();
    end
    chk("wrap_cnt", 32'(ops_done), 32'd1);

    // Reset asserted mid-APPLY discards the operation.
    req = 4'b0100; op = 8'hFF; mask = 32'hFFFF_FFFF;
    step(); check_all();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(q), 32'hA5);
    chk("async_rst_ack", 32'(ack), 32'h0);
    chk("async_rst_cnt", 32'(ops_done), 32'h0);
    model_reset();
    req = 4'b0000;
    step(); check_all();
    rst = 1'b0;
    step(); check_all();
    chk("post_rst_ack", 32'(ack), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req  = 4'($urandom);
      op   = 8'($urandom);
      mask = $urandom;
      step(); check_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
